apb_req_arbiter: RTL
====================

// Module: apb_req_arbiter
// PURPOSE
//  Two-master to one-slave APB arbiter in front of top_regfile, in the clk_200m domain.
//  m0 = mdio_top request port. m1 = secondary config master (power-on config loader / debug).
//  Registered, round-robin grant; one slave transfer in flight at a time.
//  Slave-response timeout returns PSLVERR, so a hung slave cannot lock either master.
// PARAMETERS
//  ADDR_W       21        APB address width
//  DATA_W       16        APB data width
//  TIMEOUT_CYC  64        ACCESS cycles without s_pready before forced error completion
//  ERR_DATA     16'hDEAD  m_prdata value returned on timeout
// PORTS
//  clk_200m     in   1       single clock
//  rstn_200m    in   1       asynchronous active-low reset
//  m0_psel      in   1       master0 select
//  m0_penable   in   1       master0 enable
//  m0_pwrite    in   1       master0 write=1 / read=0
//  m0_paddr     in   ADDR_W  master0 address
//  m0_pwdata    in   DATA_W  master0 write data
//  m0_pready    out  1       master0 ready
//  m0_prdata    out  DATA_W  master0 read data
//  m0_pslverr   out  1       master0 error (timeout)
//  m1_*         ---  ---     same set as m0_*, for master1
//  s_psel       out  1       slave select
//  s_penable    out  1       slave enable
//  s_pwrite     out  1       slave write
//  s_paddr      out  ADDR_W  slave address
//  s_pwdata     out  DATA_W  slave write data
//  s_pready     in   1       slave ready
//  s_prdata     in   DATA_W  slave read data
//  busy         out  1       high when state != IDLE
// BEHAVIOUR
//  Reset (async, rstn_200m=0): state=IDLE, all s_* and busy =0, last_gnt=1 (m0 wins first tie).
//  m*_pready, m*_pslverr and m*_prdata are 0 whenever that master is not completing.
//  Masters follow APB: hold psel, paddr, pwrite and pwdata until pready. A waiting master stays in its access phase.
//  FSM:
//   IDLE    req = {m1_psel, m0_psel}. On any req, pick the winner: a single requester wins.
//           On a tie, the master that is not last_gnt wins.
//           Latch gnt, paddr, pwrite and pwdata from the winner into the s_* registers. Go to SETUP.
//   SETUP   s_psel=1, s_penable=0, for exactly one cycle. Go to ACCESS and clear tcnt.
//   ACCESS  s_psel=1, s_penable=1. tcnt increments each cycle.
//           s_pready=1: m[gnt]_pready=1 and m[gnt]_prdata=s_prdata in the same cycle (combinational), pslverr=0.
//           tcnt==TIMEOUT_CYC-1 with no s_pready: m[gnt]_pready=1, m[gnt]_pslverr=1, m[gnt]_prdata=ERR_DATA.
//           Either way: last_gnt<=gnt, go to DONE.
//   DONE    All s_* =0 for one turnaround cycle. Go to IDLE.
//  Latency, uncontended: psel at cycle N -> s_psel at N+1 -> s_penable at N+2.
//   With a zero-wait slave, m_pready at N+2. Back-to-back spacing: 4 cycles per transfer.
//  Simultaneous events:
//   s_pready and timeout in the same cycle: the s_pready completion wins, pslverr=0.
//   A new request arriving during SETUP/ACCESS/DONE waits. No preemption.
//  Granted master drops psel before completion (protocol violation): the slave transfer still finishes.
//   The response is not forwarded; last_gnt still updates.
//  Grant fairness: under continuous requests from both masters, grants strictly alternate.
//  tcnt width = $clog2(TIMEOUT_CYC). No carry or wrap past TIMEOUT_CYC-1.
//  Reset mid-transfer: s_psel drops asynchronously. The pending master sees no pready until re-issued.
// STRUCTURE
//  ctrl_sys_defs.vh: FSM state encodings (IDLE=2'd0, SETUP=1, ACCESS=2, DONE=3), default ERR_DATA.
//  Sub-module rr_arb2: 2-way round-robin picker.
//   Inputs req[1:0] and last_gnt. Output gnt_idx. Combinational; last_gnt register lives in the parent.
//  Parent holds the FSM, address/data capture registers, timeout counter and response demux.
// TESTING
//  1 Reset: hold rstn_200m=0 -> all outputs 0, busy=0. Release; first tie grants m0.
//  2 Single m0 write 0x00010/0xA5A5, zero-wait slave ->
//    s_psel@N+1, s_penable@N+2, s_pwdata=16'hA5A5, m0_pready@N+2, m1 untouched.
//  3 m0 and m1 request in the same cycle, 4 transfers each ->
//    grant order m0,m1,m0,m1,...; m1_pready stays 0 while m0 is served.
//  4 m1 read, slave inserts 3 wait states, s_prdata=16'h1234 ->
//    m1_prdata=16'h1234 with m1_pready exactly on the slave pready cycle.
//  5 Slave never asserts s_pready, TIMEOUT_CYC=64 ->
//    m0_pready=m0_pslverr=1 and m0_prdata=16'hDEAD at ACCESS cycle 64. Next request served normally.
//  6 Assert rstn_200m low during m1 ACCESS ->
//    s_psel=0 immediately, state=IDLE; after release, a re-issued m1 request completes.

Source files
------------

// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and defaults for the two-master APB request arbiter.
// State encodings are fixed so they line up with the register-map documentation.
package apb_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

endpackage

// File: rtl/apb_req_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the master
// that was not granted last. Purely combinational; last_gnt lives in the parent.
module apb_req_arbiter_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       gnt_idx_o
);

    always_comb begin
        gnt_idx_o = 1'b0;
        case (req_i)
            2'b01:   gnt_idx_o = 1'b0;
            2'b10:   gnt_idx_o = 1'b1;
            2'b11:   gnt_idx_o = ~last_gnt_i;
            default: gnt_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-master to one-slave APB arbiter with registered round-robin grant and a
// slave-response timeout that completes the transfer with PSLVERR.
//
// state  | meaning
// IDLE   | no transfer; pick a winner and capture its address/data
// SETUP  | s_psel=1, s_penable=0 for one cycle
// ACCESS | s_psel=1, s_penable=1; wait for s_pready or timeout
// DONE   | one turnaround cycle with all s_* low
module apb_req_arbiter
    import apb_req_arbiter_pkg::*;
#(
    parameter int                ADDR_W      = 21,
    parameter int                DATA_W      = 16,
    parameter int                TIMEOUT_CYC = 64,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              clk_200m,
    input  logic              rstn_200m,

    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic              m0_pready,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pslverr,

    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic              m1_pready,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pslverr,

    output logic              s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    output logic [ADDR_W-1:0] s_paddr,
    output logic [DATA_W-1:0] s_pwdata,
    input  logic              s_pready,
    input  logic [DATA_W-1:0] s_prdata,

    output logic              busy
);

    localparam int                TCNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;

    logic [1:0]        req;
    logic              win_idx;
    logic              cmpl;
    logic              cmpl_err;
    logic [DATA_W-1:0] rsp_data;
    logic              fwd0;
    logic              fwd1;

    assign req = {m1_psel, m0_psel};

    apb_req_arbiter_rr_arb2 u_rr_arb2 (
        .req_i      (req),
        .last_gnt_i (last_gnt_q),
        .gnt_idx_o  (win_idx)
    );

    always_ff @(posedge clk_200m or negedge rstn_200m) begin
        if (!rstn_200m) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            tcnt_q     <= tcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        tcnt_d     = tcnt_q;
        cmpl       = 1'b0;
        cmpl_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = win_idx;
                    addr_d  = win_idx ? m1_paddr  : m0_paddr;
                    write_d = win_idx ? m1_pwrite : m0_pwrite;
                    wdata_d = win_idx ? m1_pwdata : m0_pwdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                tcnt_d  = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A real slave response outranks a timeout landing in the same cycle.
                if (s_pready) begin
                    cmpl = 1'b1;
                end else if (tcnt_q == TCNT_LAST) begin
                    cmpl     = 1'b1;
                    cmpl_err = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (cmpl) begin
                    last_gnt_d = gnt_q;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decoded straight from state so an async reset drops the slave bus at once.
    assign s_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign s_penable = (state_q == ST_ACCESS);
    assign s_pwrite  = s_psel & write_q;
    assign s_paddr   = s_psel ? addr_q  : '0;
    assign s_pwdata  = s_psel ? wdata_q : '0;
    assign busy      = (state_q != ST_IDLE);

    // A master that abandoned its access phase gets no response.
    assign rsp_data = cmpl_err ? ERR_DATA : s_prdata;
    assign fwd0     = cmpl & ~gnt_q & m0_psel & m0_penable;
    assign fwd1     = cmpl &  gnt_q & m1_psel & m1_penable;

    assign m0_pready  = fwd0;
    assign m0_pslverr = fwd0 & cmpl_err;
    assign m0_prdata  = fwd0 ? rsp_data : '0;

    assign m1_pready  = fwd1;
    assign m1_pslverr = fwd1 & cmpl_err;
    assign m1_prdata  = fwd1 ? rsp_data : '0;

endmodule
